// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Steps one shared memory, ALU and register file through fetch, decode,
// execute, memory and writeback. It also produces a retire pulse and
// keeps a retired-instruction counter.
//
// Handshake: mem_ready is sampled in FETCH, MEM_RD and MEM_WR.
// A memory access completes in the cycle where the access strobe is high
// and rdy is high. The FSM holds the strobe and stays in the state until
// that cycle.
//
// Most control outputs depend on state only. They are registered from the
// next state so they are glitch-free. The outputs that also depend on rdy
// are built by combining a registered state flag with rdy:
// ir_write/pc_write in FETCH and retire in MEM_WR.
module mips_multicycle_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    JUMP      = 4'd11,
    JAL       = 4'd12,
    JR        = 4'd13
  } state_t;

  state_t st, nxt;
  logic   rdy;
  logic   illegal;
  logic   in_fetch;
  logic   in_memwr;
  logic   pc_write_r;
  logic   retire_r;

  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // Next-state decode. The opcode is only looked at in DECODE and MEM_ADR.
  always_comb begin
    nxt     = FETCH;
    illegal = 1'b0;
    case (st)
      FETCH:     nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          6'b100011, 6'b101011: nxt = MEM_ADR;
          6'b000000:            nxt = (funct == 6'b001000) ? JR : R_EXEC;
          6'b000100:            nxt = BRANCH;
          6'b001000:            nxt = ADDI_EXEC;
          6'b000010:            nxt = JUMP;
          6'b000011:            nxt = JAL;
          default: begin
            nxt     = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEM_ADR:   nxt = (opcode == 6'b100011) ? MEM_RD : MEM_WR;
      MEM_RD:    nxt = rdy ? MEM_WB : MEM_RD;
      MEM_WB:    nxt = FETCH;
      MEM_WR:    nxt = rdy ? FETCH : MEM_WR;
      R_EXEC:    nxt = R_WB;
      R_WB:      nxt = FETCH;
      BRANCH:    nxt = FETCH;
      ADDI_EXEC: nxt = ADDI_WB;
      ADDI_WB:   nxt = FETCH;
      JUMP:      nxt = FETCH;
      JAL:       nxt = FETCH;
      JR:        nxt = FETCH;
      default:   nxt = FETCH;
    endcase
  end

  // State register, registered Moore outputs for the next state, and the
  // retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= FETCH;
      in_fetch      <= 1'b1;
      in_memwr      <= 1'b0;
      pc_write_r    <= 1'b0;
      retire_r      <= 1'b0;
      pc_write_cond <= 1'b0;
      iord          <= 1'b0;
      mem_read      <= 1'b1;
      mem_write     <= 1'b0;
      reg_dst       <= 2'b00;
      mem_to_reg    <= 2'b00;
      reg_write     <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b01;
      alu_op        <= 2'b00;
      pc_src        <= 2'b00;
      instr_count   <= '0;
    end else begin
      st            <= nxt;
      in_fetch      <= 1'b0;
      in_memwr      <= 1'b0;
      pc_write_r    <= 1'b0;
      retire_r      <= 1'b0;
      pc_write_cond <= 1'b0;
      iord          <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      reg_dst       <= 2'b00;
      mem_to_reg    <= 2'b00;
      reg_write     <= 1'b0;
      alu_src_a     <= 1'b0;
      alu_src_b     <= 2'b00;
      alu_op        <= 2'b00;
      pc_src        <= 2'b00;
      case (nxt)
        FETCH: begin
          in_fetch  <= 1'b1;
          mem_read  <= 1'b1;
          alu_src_b <= 2'b01;
        end
        DECODE:    alu_src_b <= 2'b11;
        MEM_ADR: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
        end
        MEM_RD: begin
          iord     <= 1'b1;
          mem_read <= 1'b1;
        end
        MEM_WB: begin
          mem_to_reg <= 2'b01;
          reg_write  <= 1'b1;
          retire_r   <= 1'b1;
        end
        MEM_WR: begin
          in_memwr  <= 1'b1;
          iord      <= 1'b1;
          mem_write <= 1'b1;
        end
        R_EXEC: begin
          alu_src_a <= 1'b1;
          alu_op    <= 2'b10;
        end
        R_WB: begin
          reg_dst   <= 2'b01;
          reg_write <= 1'b1;
          retire_r  <= 1'b1;
        end
        BRANCH: begin
          alu_src_a     <= 1'b1;
          alu_op        <= 2'b01;
          pc_src        <= 2'b01;
          pc_write_cond <= 1'b1;
          retire_r      <= 1'b1;
        end
        ADDI_EXEC: begin
          alu_src_a <= 1'b1;
          alu_src_b <= 2'b10;
        end
        ADDI_WB: begin
          reg_write <= 1'b1;
          retire_r  <= 1'b1;
        end
        JUMP: begin
          pc_src     <= 2'b10;
          pc_write_r <= 1'b1;
          retire_r   <= 1'b1;
        end
        // The PC register already holds PC+4 here. The register file
        // captures it at the same edge where the PC takes the jump target.
        JAL: begin
          pc_src     <= 2'b10;
          pc_write_r <= 1'b1;
          reg_dst    <= 2'b10;
          mem_to_reg <= 2'b10;
          reg_write  <= 1'b1;
          retire_r   <= 1'b1;
        end
        JR: begin
          pc_src     <= 2'b11;
          pc_write_r <= 1'b1;
          retire_r   <= 1'b1;
        end
        default: ;
      endcase
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign ir_write   = in_fetch & rdy;
  assign pc_write   = pc_write_r | (in_fetch & rdy);
  assign retire     = retire_r | (in_memwr & rdy);
  assign illegal_op = illegal;
  assign state      = st;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl.
// A reference model walks a per-opcode path of states. In FETCH, MEM_RD
// and MEM_WR it holds its position on cycles where mem_ready is low. Each
// cycle the DUT's state, all control outputs and the counter are compared
// with the values the model predicts.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic        reg_write, alu_src_a, retire, illegal_op;
  logic [31:0] instr_count;
  logic [3:0]  state;
  logic [19:0] ctrl_vec;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_count = 0;
  logic [31:0] exp_q[$];

  mips_multicycle_ctrl #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .retire(retire), .illegal_op(illegal_op),
    .instr_count(instr_count), .state(state)
  );

  assign ctrl_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                     alu_op, pc_src, retire, illegal_op};

  // Clock generation: 10 ns period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control word for a state, taken from the state output table.
  function automatic logic [19:0] exp_ctrl(input int st, input logic rdy,
                                           input logic ret, input logic ill);
    logic pw, pwc, io, mr, mw, irw, rw, asa;
    logic [1:0] rd, m2r, asb, aop, ps;
    {pw, pwc, io, mr, mw, irw, rw, asa} = '0;
    {rd, m2r, asb, aop, ps} = '0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin io = 1; mr = 1; end
      4:  begin m2r = 2'b01; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 2'b01; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; ps = 2'b01; pwc = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      12: begin ps = 2'b10; pw = 1; rd = 2'b10; m2r = 2'b10; rw = 1; end
      13: begin ps = 2'b11; pw = 1; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ps, ret, ill};
  endfunction

  // Runs one instruction against the model. Call it just after a rising edge.
  // In force_st the first force_n cycles have mem_ready low. Every other
  // cycle has mem_ready low with probability low_pct percent.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input int low_pct, input int force_st, input int force_n,
                           output int cycles);
    int p[$];
    int idx, st_e, force_left;
    logic ill, adv, ret_e, ill_e;
    ill = 1'b0;
    case (opc)
      6'h23:   p = '{0, 1, 2, 3, 4};
      6'h2b:   p = '{0, 1, 2, 5};
      6'h00: begin
        if (fn == 6'h08) p = '{0, 1, 13};
        else             p = '{0, 1, 6, 7};
      end
      6'h04:   p = '{0, 1, 8};
      6'h08:   p = '{0, 1, 9, 10};
      6'h02:   p = '{0, 1, 11};
      6'h03:   p = '{0, 1, 12};
      default: begin p = '{0, 1}; ill = 1'b1; end
    endcase
    opcode = opc;
    funct  = fn;
    idx = 0;
    cycles = 0;
    force_left = force_n;
    while (idx < p.size() && cycles < 200) begin
      @(negedge clk);
      st_e = p[idx];
      if (st_e == force_st && force_left > 0) begin
        mem_ready = 1'b0;
        force_left--;
      end else begin
        mem_ready = ($urandom_range(99) < low_pct) ? 1'b0 : 1'b1;
      end
      #1;
      adv   = !(st_e == 0 || st_e == 3 || st_e == 5) || mem_ready;
      ret_e = adv && (idx == p.size() - 1) && !ill;
      ill_e = (st_e == 1) && ill;
      check("state", {28'd0, state}, st_e);
      check("ctrl", {12'd0, ctrl_vec}, {12'd0, exp_ctrl(st_e, mem_ready, ret_e, ill_e)});
      check("count", instr_count, exp_count);
      @(posedge clk);
      #1;
      cycles++;
      if (ret_e) exp_count = exp_count + 1;
      if (adv) idx++;
    end
    check("bound", idx, p.size());
  endtask

  // Stimulus sequence.
  initial begin
    int cyc, total, r;
    logic [5:0] opc, fn;
    logic [5:0] ops[8];
    logic [5:0] rfn[5];
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h03, 6'h00};
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    #1;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_count", instr_count, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", {12'd0, ctrl_vec}, {12'd0, exp_ctrl(0, 1'b0, 1'b0, 1'b0)});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // lw with mem_ready always high: 5 cycles, count 0 -> 1.
    run_instr(6'h23, 6'h00, 0, -1, 0, cyc);
    check("lw_cycles", cyc, 32'd5);
    check("lw_count", instr_count, 32'd1);

    // sw with 3 low cycles in MEM_WR: 7 cycles in total.
    run_instr(6'h2b, 6'h00, 0, 5, 3, cyc);
    check("sw_cycles", cyc, 32'd7);

    // Directed run of the other instruction classes.
    run_instr(6'h00, 6'h20, 0, -1, 0, cyc);
    check("r_cycles", cyc, 32'd4);
    run_instr(6'h00, 6'h08, 0, -1, 0, cyc);
    check("jr_cycles", cyc, 32'd3);
    run_instr(6'h04, 6'h00, 0, -1, 0, cyc);
    check("beq_cycles", cyc, 32'd3);
    run_instr(6'h03, 6'h00, 0, -1, 0, cyc);
    check("jal_cycles", cyc, 32'd3);
    run_instr(6'h02, 6'h00, 0, -1, 0, cyc);
    run_instr(6'h3f, 6'h00, 0, -1, 0, cyc);
    check("illegal_cycles", cyc, 32'd2);
    check("illegal_count", instr_count, exp_count);

    // 20 back-to-back addi: 80 cycles, 20 retirements.
    exp_q.push_back(instr_count + 20);
    total = 0;
    for (int i = 0; i < 20; i++) begin
      run_instr(6'h08, 6'h00, 0, -1, 0, cyc);
      total += cyc;
    end
    check("addi_cycles", total, 32'd80);
    check("addi_count", instr_count, exp_q.pop_front());

    // Reset held for 150 ns in the middle of an lw's MEM_RD.
    opcode = 6'h23;
    funct = 6'h00;
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("pre_rst_state", {28'd0, state}, 32'd3);
    rst = 1'b1;
    exp_count = 0;
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    repeat (7) begin
      #20;
      check("rst_hold_state", {28'd0, state}, 32'd0);
      check("rst_hold_count", instr_count, 32'd0);
      check("rst_hold_ctrl", {12'd0, ctrl_vec}, {12'd0, exp_ctrl(0, mem_ready, 1'b0, 1'b0)});
    end
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_instr(6'h23, 6'h00, 0, -1, 0, cyc);
    check("post_rst_lw_cycles", cyc, 32'd5);

    // Random instructions with random mem_ready stalls.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(9);
      if (r < 8) opc = ops[r];
      else       opc = 6'($urandom_range(63));
      if (r == 7)      fn = 6'h08;
      else if (r == 2) fn = rfn[$urandom_range(4)];
      else             fn = 6'($urandom_range(63));
      run_instr(opc, fn, 30, -1, 0, cyc);
    end
    check("final_count", instr_count, exp_count);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
